// File: rtl/ps2_cmd_arbiter.sv
// ps2_cmd_arbiter
// Round-robin arbiter that lets several command FSMs share one ps2_rxtx
// transmit path. One command byte is in flight at a time: the byte is
// written, the arbiter waits for the transmit to finish, then waits for the
// device reply. 0xFA completes with done, 0xFE or a timeout triggers a
// bounded number of resends, and any other reply fails immediately with err.
//
// Handshake: a requester raises req[i] with its byte on cmd_data[8i+7:8i]
// and holds req until it sees a one-cycle done[i] or err[i] pulse. The byte
// is captured when grant[i] rises, so cmd_data may change afterwards.
module ps2_cmd_arbiter #(
    parameter int N_REQ       = 3,
    parameter int ACK_TIMEOUT = 2000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] cmd_data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic [7:0]         resp_byte,
    output logic               busy,
    output logic               wr_ps2,
    output logic [7:0]         tx_data,
    input  logic               tx_done_tick,
    input  logic               rx_done_tick,
    input  logic [7:0]         rx_data,
    output logic [1:0]         state_dbg
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int IDX_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);

    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ACK_TIMEOUT);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam logic [7:0] RESP_RESEND = 8'hFE;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_TX  = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic [7:0]         resp_q, resp_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [IDX_W-1:0]   last_q, last_d;

    // Arbitration results
    logic [N_REQ-1:0]   req_avail;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [7:0]         pick_cmd;
    int                 cand;

    // Transaction-ending decisions
    logic               fail;
    logic [7:0]         fail_resp;
    logic               fin_done;
    logic               fin_err;
    logic [7:0]         fin_resp;

    // Round-robin pick: search from the slot after the last winner, wrapping.
    // The requester whose done/err is pulsing right now is masked so its
    // still-high req is not mistaken for a fresh request.
    always_comb begin
        req_avail  = req & ~(done_q | err_q);
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_q) + k) % N_REQ;
            if (!pick_found && req_avail[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
        pick_cmd = cmd_data[8*int'(pick_idx) +: 8];
    end

    // Transaction sequencer: next state, counters, and completion pulses
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        resp_d    = resp_q;
        tx_data_d = tx_data_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        last_d    = last_q;
        fail      = 1'b0;
        fail_resp = 8'h00;
        fin_done  = 1'b0;
        fin_err   = 1'b0;
        fin_resp  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    tx_data_d = pick_cmd;
                    retry_d   = '0;
                    last_d    = pick_idx;
                    state_d   = S_SEND;
                end
            end

            S_SEND: begin
                tmo_d   = '0;
                state_d = S_WAIT_TX;
            end

            S_WAIT_TX: begin
                // A received byte here is not the reply to our command yet
                if (tx_done_tick) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_ACK;
                end else if (tmo_q == TMO_MAX) begin
                    fail      = 1'b1;
                    fail_resp = 8'h00;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_WAIT_ACK: begin
                if (rx_done_tick) begin
                    if (rx_data == RESP_ACK) begin
                        fin_done = 1'b1;
                        fin_resp = rx_data;
                    end else if (rx_data == RESP_RESEND) begin
                        fail      = 1'b1;
                        fail_resp = rx_data;
                    end else begin
                        fin_err  = 1'b1;
                        fin_resp = rx_data;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    fail      = 1'b1;
                    fail_resp = 8'h00;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Resend the same byte while retries remain, otherwise give up
        if (fail) begin
            if (retry_q < RTY_MAX) begin
                retry_d = retry_q + RTY_W'(1);
                state_d = S_SEND;
            end else begin
                fin_err  = 1'b1;
                fin_resp = fail_resp;
            end
        end

        // Completion: pulse the owner, release the grant, back to IDLE
        if (fin_done || fin_err) begin
            done_d  = fin_done ? grant_q : '0;
            err_d   = fin_err ? grant_q : '0;
            resp_d  = fin_resp;
            grant_d = '0;
            state_d = S_IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            resp_q    <= 8'h00;
            tx_data_q <= 8'h00;
            retry_q   <= '0;
            tmo_q     <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            resp_q    <= resp_d;
            tx_data_q <= tx_data_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            last_q    <= last_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign err       = err_q;
    assign resp_byte = resp_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != S_IDLE);
    assign wr_ps2    = (state_q == S_SEND);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Directed testbench for ps2_cmd_arbiter (3 requesters, short timeout).
module tb_ps2_cmd_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] cmd_data;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [7:0]  resp_byte;
    logic        busy;
    logic        wr_ps2;
    logic [7:0]  tx_data;
    logic        tx_done_tick;
    logic        rx_done_tick;
    logic [7:0]  rx_data;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    int wr_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    ps2_cmd_arbiter #(
        .N_REQ(3),
        .ACK_TIMEOUT(100),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .cmd_data(cmd_data),
        .grant(grant),
        .done(done),
        .err(err),
        .resp_byte(resp_byte),
        .busy(busy),
        .wr_ps2(wr_ps2),
        .tx_data(tx_data),
        .tx_done_tick(tx_done_tick),
        .rx_done_tick(rx_done_tick),
        .rx_data(rx_data),
        .state_dbg(state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (wr_ps2)  wr_cnt   <= wr_cnt + 1;
        if (|done)   done_cnt <= done_cnt + 1;
        if (|err)    err_cnt  <= err_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_tx();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic do_rx(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
    endtask

    logic [2:0] exp_g[4];
    logic [7:0] exp_b[4];
    int wr0, done0, err0;
    int k;
    logic pw;

    initial begin
        rst          = 1'b1;
        req          = 3'b000;
        cmd_data     = 24'h0;
        tx_done_tick = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        tick();
        tick();

        // Reset state
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr", 32'(wr_ps2), 32'h0);
        chk("rst_txdata", 32'(tx_data), 32'h00);
        chk("rst_resp", 32'(resp_byte), 32'h00);
        chk("rst_doneerr", 32'({done, err}), 32'h0);
        rst = 1'b0;
        tick();

        // T1: single command acknowledged
        wr0 = wr_cnt; done0 = done_cnt; err0 = err_cnt;
        cmd_data = 24'h0000FF;
        req      = 3'b001;
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_wr", 32'(wr_ps2), 32'h1);
        chk("t1_txdata", 32'(tx_data), 32'hFF);
        chk("t1_busy", 32'(busy), 32'h1);
        cmd_data = 24'h000012;
        tick();
        chk("t1_wr_one_cycle", 32'(wr_ps2), 32'h0);
        chk("t1_txdata_latched", 32'(tx_data), 32'hFF);
        do_tx();
        do_rx(8'hFA);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_resp", 32'(resp_byte), 32'hFA);
        chk("t1_grant_drop", 32'(grant), 32'h0);
        chk("t1_idle", 32'(busy), 32'h0);
        req = 3'b000;
        tick();
        chk("t1_done_pulse", 32'(done), 32'h0);
        chk("t1_wr_count", 32'(wr_cnt - wr0), 32'd1);
        chk("t1_done_count", 32'(done_cnt - done0), 32'd1);

        // T2: round-robin rotation with all requests held (fresh pointer)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        exp_b[0] = 8'h11;  exp_b[1] = 8'h22;  exp_b[2] = 8'h33;  exp_b[3] = 8'h11;
        cmd_data = 24'h332211;
        req      = 3'b111;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_grant%0d", i), 32'(grant), 32'(exp_g[i]));
            chk($sformatf("t2_tx%0d", i), 32'(tx_data), 32'(exp_b[i]));
            tick();
            do_tx();
            do_rx(8'hFA);
            chk($sformatf("t2_done%0d", i), 32'(done), 32'(exp_g[i]));
            chk($sformatf("t2_gap%0d", i), 32'(grant), 32'h0);
            if (i == 3) req = 3'b000;
            tick();
        end
        chk("t2_end_idle", 32'(busy), 32'h0);

        // T3: two resend replies then ack
        wr0 = wr_cnt; done0 = done_cnt; err0 = err_cnt;
        cmd_data = 24'h0000F4;
        req      = 3'b001;
        tick();
        tick();
        do_tx();
        do_rx(8'hFE);
        chk("t3_resend1_wr", 32'(wr_ps2), 32'h1);
        chk("t3_resend1_grant", 32'(grant), 32'h1);
        chk("t3_resend1_tx", 32'(tx_data), 32'hF4);
        tick();
        do_tx();
        do_rx(8'hFE);
        chk("t3_resend2_wr", 32'(wr_ps2), 32'h1);
        tick();
        do_tx();
        do_rx(8'hFA);
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_no_err", 32'(err), 32'h0);
        req = 3'b000;
        tick();
        chk("t3_wr_count", 32'(wr_cnt - wr0), 32'd3);
        chk("t3_done_count", 32'(done_cnt - done0), 32'd1);
        chk("t3_err_count", 32'(err_cnt - err0), 32'd0);

        // T4: device never answers -> 4 attempts then err with 0x00
        wr0 = wr_cnt; done0 = done_cnt; err0 = err_cnt;
        cmd_data = 24'h00ED00;
        req      = 3'b010;
        pw       = 1'b0;
        for (k = 0; k < 2000; k++) begin
            if (err != 3'b000 || done != 3'b000) break;
            tx_done_tick = pw;
            pw = wr_ps2;
            tick();
        end
        tx_done_tick = 1'b0;
        chk("t4_finished_in_time", 32'(k < 2000), 32'h1);
        chk("t4_err", 32'(err), 32'h2);
        chk("t4_done", 32'(done), 32'h0);
        chk("t4_resp", 32'(resp_byte), 32'h00);
        req = 3'b000;
        tick();
        chk("t4_wr_count", 32'(wr_cnt - wr0), 32'd4);
        chk("t4_err_count", 32'(err_cnt - err0), 32'd1);

        // T5: unexpected reply fails immediately; rx in IDLE ignored
        wr0 = wr_cnt;
        cmd_data = 24'hAB0000;
        req      = 3'b100;
        tick();
        chk("t5_grant", 32'(grant), 32'h4);
        tick();
        do_tx();
        do_rx(8'hFC);
        chk("t5_err", 32'(err), 32'h4);
        chk("t5_resp", 32'(resp_byte), 32'hFC);
        req = 3'b000;
        tick();
        chk("t5_wr_count", 32'(wr_cnt - wr0), 32'd1);
        do_rx(8'h55);
        chk("t5_idle_rx_busy", 32'(busy), 32'h0);
        chk("t5_idle_rx_resp", 32'(resp_byte), 32'hFC);
        chk("t5_idle_rx_pulses", 32'({grant, done, err, wr_ps2}), 32'h0);

        // T6: reset while waiting for the reply, then a normal grant
        err0 = err_cnt; done0 = done_cnt;
        cmd_data = 24'h0000F3;
        req      = 3'b001;
        tick();
        tick();
        do_tx();
        chk("t6_in_wait_ack", 32'(state_dbg), 32'd3);
        req = 3'b000;
        rst = 1'b1;
        tick();
        chk("t6_rst_outputs", 32'({grant, done, err, busy, wr_ps2}), 32'h0);
        chk("t6_rst_bytes", 32'({resp_byte, tx_data}), 32'h0);
        rst = 1'b0;
        tick();
        chk("t6_no_pulse", 32'((err_cnt - err0) + (done_cnt - done0)), 32'd0);
        cmd_data = 24'h00A500;
        req      = 3'b010;
        tick();
        chk("t6_grant", 32'(grant), 32'h2);
        chk("t6_tx", 32'(tx_data), 32'hA5);
        tick();
        do_tx();
        do_rx(8'hFA);
        chk("t6_done", 32'(done), 32'h2);
        req = 3'b000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
